// File: rtl/lock_ctrl_pkg.sv
// Shared types and widths for the keypad/lock access controller.
// Holds the FSM state encoding, key/progress widths and a timer-width helper.
// No logic of its own; imported by the interface, arbiter and controller.
package lock_ctrl_pkg;

  localparam int KEY_W  = 4;
  localparam int PROG_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_OPEN    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_LOCKOUT = 3'd5
  } lock_state_e;

  // One width fits every timer: enough bits for the largest count plus a spare
  // so no counter can wrap while it is still being compared.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lock_access_ctrl_if.sv
// Bundle between the keypads / lock FSM and the access controller.
// Pure wiring; no latency of its own.
// master = keypads and lock FSM side, slave = the controller.
interface lock_access_ctrl_if;
  import lock_ctrl_pkg::*;

  logic [1:0]        req;
  logic [KEY_W-1:0]  keys0;
  logic [KEY_W-1:0]  keys1;
  logic [1:0]        grant;
  logic [KEY_W-1:0]  lock_keys;
  logic              lock_rst;
  logic              lock_unlock;
  logic [PROG_W-1:0] lock_progress;
  logic              unlocked;
  logic              locked_out;
  logic [1:0]        fail_count;

  modport master (
    output req, keys0, keys1, lock_unlock, lock_progress,
    input  grant, lock_keys, lock_rst, unlocked, locked_out, fail_count
  );

  modport slave (
    input  req, keys0, keys1, lock_unlock, lock_progress,
    output grant, lock_keys, lock_rst, unlocked, locked_out, fail_count
  );

endinterface

// File: rtl/lock_rr_arb.sv
// Two-way round-robin pick between keypad requests.
// Combinational; the parent registers the result as the grant.
// en=0 forces no pick; on a tie the keypad not granted last wins.
module lock_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // last=1 means keypad 1 owned the previous session, so a tie goes to keypad 0.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/lock_access_ctrl.sv
// Shares one combination lock between two keypads, one session at a time, with lockout.
// Grant one cycle after a request in IDLE; unlocked one cycle after lock_unlock.
// No queuing: requests are only looked at in IDLE and are ignored during a lockout.
module lock_access_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int SESSION_TIMEOUT = 64,
  parameter int HOLD_CYCLES     = 8,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 100
) (
  input  logic             clk,
  input  logic             reset,
  lock_access_ctrl_if.slave bus
);

  localparam int TMR_W = timer_width(SESSION_TIMEOUT, HOLD_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(SESSION_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] LO_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAILS);

  lock_state_e       state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              owner_q, owner_d;   // keypad index of the current session
  logic              last_q, last_d;     // keypad index of the previous session
  logic [1:0]        fail_q, fail_d;
  logic [TMR_W-1:0]  idle_q, idle_d;
  logic [TMR_W-1:0]  hold_q, hold_d;
  logic [TMR_W-1:0]  lo_q, lo_d;
  logic              seen_q, seen_d;
  logic [PROG_W-1:0] prog_q;
  logic              rst_pulse_q;

  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic [KEY_W-1:0]  fwd_keys;
  logic              prog_chg;
  logic [1:0]        fail_inc;

  assign arb_en   = (state_q == ST_IDLE);
  assign fwd_keys = owner_q ? bus.keys1 : bus.keys0;
  assign prog_chg = (bus.lock_progress != prog_q);
  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 2'd1;

  lock_rr_arb u_arb (
    .req  (bus.req),
    .last (last_q),
    .en   (arb_en),
    .gnt  (arb_gnt)
  );

  // Only the owning keypad reaches the lock, and only while the session is live.
  assign bus.grant      = grant_q;
  assign bus.lock_keys  = (state_q == ST_ACTIVE) ? fwd_keys : '0;
  assign bus.lock_rst   = rst_pulse_q | (state_q == ST_CLEAR) | (state_q == ST_RELEASE);
  assign bus.unlocked   = (state_q == ST_OPEN);
  assign bus.locked_out = (state_q == ST_LOCKOUT);
  assign bus.fail_count = fail_q;

  // Session sequencing: next state plus the timer, counter and pointer updates it implies.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    fail_d  = fail_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    lo_d    = lo_q;
    seen_d  = seen_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = ST_CLEAR;
          grant_d = arb_gnt;
          owner_d = arb_gnt[1];
        end
      end
      ST_CLEAR: begin
        idle_d  = '0;
        seen_d  = 1'b0;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (fwd_keys != '0) seen_d = 1'b1;
        idle_d = prog_chg ? '0 : idle_q + 1'b1;
        if (bus.lock_unlock) begin
          state_d = ST_OPEN;
          fail_d  = 2'd0;
          hold_d  = '0;
        end else if (!bus.req[owner_q]) begin
          // Walking away before touching a key is not an attempt.
          state_d = ST_RELEASE;
          grant_d = 2'b00;
          if (seen_q || (fwd_keys != '0)) fail_d = fail_inc;
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_RELEASE;
          grant_d = 2'b00;
          fail_d  = fail_inc;
        end
      end
      ST_OPEN: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          grant_d = 2'b00;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        last_d = owner_q;
        if (fail_q == FAIL_MAX) begin
          state_d = ST_LOCKOUT;
          lo_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lo_q == LO_LAST) begin
          state_d = ST_IDLE;
          fail_d  = 2'd0;
        end else begin
          lo_d = lo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State register; reset aborts any session and pulses the lock reset once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      fail_q      <= 2'd0;
      idle_q      <= '0;
      hold_q      <= '0;
      lo_q        <= '0;
      seen_q      <= 1'b0;
      prog_q      <= '0;
      rst_pulse_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      fail_q      <= fail_d;
      idle_q      <= idle_d;
      hold_q      <= hold_d;
      lo_q        <= lo_d;
      seen_q      <= seen_d;
      prog_q      <= bus.lock_progress;
      rst_pulse_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed scenarios for the keypad/lock access controller.
// The lock FSM is stood in for by directly driving lock_unlock and lock_progress.
// Outputs are sampled 1 time unit after each rising edge.
module tb_lock_access_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  lock_access_ctrl_if bus ();

  lock_access_ctrl #(
    .SESSION_TIMEOUT (64),
    .HOLD_CYCLES     (8),
    .MAX_FAILS       (3),
    .LOCKOUT_CYCLES  (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    if (bus.grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b expected 00", bus.grant); end
    vectors++;
    if (bus.lock_rst !== 1'b1) begin miscompares++; $display("FAIL rst_lock_rst: got %b expected 1", bus.lock_rst); end
    vectors++;
    if ({bus.unlocked, bus.locked_out, bus.fail_count, bus.lock_keys} !== 8'h00) begin
      miscompares++; $display("FAIL rst_outputs: got %h expected 00", {bus.unlocked, bus.locked_out, bus.fail_count, bus.lock_keys});
    end
    vectors++;
    reset = 1'b1;
    tick();
    if (bus.lock_rst !== 1'b0) begin miscompares++; $display("FAIL rst_pulse_end: got %b expected 0", bus.lock_rst); end
    vectors++;
  endtask

  // Count consecutive unlocked cycles starting in the first OPEN cycle.
  task automatic count_open(input string tag);
    int n;
    n = 0;
    while (bus.unlocked === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    if (n != 8) begin miscompares++; $display("FAIL %s_hold: got %0d cycles expected 8", tag, n); end
    vectors++;
    if (bus.grant !== 2'b00 || bus.lock_rst !== 1'b1) begin
      miscompares++; $display("FAIL %s_release: got grant=%b lock_rst=%b expected 00/1", tag, bus.grant, bus.lock_rst);
    end
    vectors++;
  endtask

  task automatic test_open();
    bus.req = 2'b01; bus.keys0 = 4'h5;
    tick();
    if (bus.grant !== 2'b01) begin miscompares++; $display("FAIL open_grant: got %b expected 01", bus.grant); end
    vectors++;
    if (bus.lock_rst !== 1'b1 || bus.lock_keys !== 4'h0) begin
      miscompares++; $display("FAIL open_clear: got lock_rst=%b keys=%h expected 1/0", bus.lock_rst, bus.lock_keys);
    end
    vectors++;
    tick();
    if (bus.lock_keys !== 4'h5 || bus.lock_rst !== 1'b0) begin
      miscompares++; $display("FAIL open_active: got keys=%h lock_rst=%b expected 5/0", bus.lock_keys, bus.lock_rst);
    end
    vectors++;
    bus.lock_unlock = 1'b1;
    tick();
    bus.lock_unlock = 1'b0; bus.keys0 = 4'h0;
    if (bus.unlocked !== 1'b1 || bus.lock_keys !== 4'h0) begin
      miscompares++; $display("FAIL open_unlocked: got unlocked=%b keys=%h expected 1/0", bus.unlocked, bus.lock_keys);
    end
    vectors++;
    count_open("open");
    if (bus.fail_count !== 2'd0) begin miscompares++; $display("FAIL open_fails: got %0d expected 0", bus.fail_count); end
    vectors++;
    bus.req = 2'b00;
    tick();
    if (bus.lock_rst !== 1'b0) begin miscompares++; $display("FAIL open_idle: got lock_rst=%b expected 0", bus.lock_rst); end
    vectors++;
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    tick();
    reset = 1'b1; bus.req = 2'b11; bus.keys0 = 4'h0; bus.keys1 = 4'h9;
    tick();
    if (bus.grant !== 2'b01) begin miscompares++; $display("FAIL rr_first: got %b expected 01", bus.grant); end
    vectors++;
    tick();
    if (bus.lock_keys !== 4'h0) begin miscompares++; $display("FAIL rr_no_keys1: got %h expected 0", bus.lock_keys); end
    vectors++;
    bus.keys0 = 4'h6;
    #1;
    if (bus.lock_keys !== 4'h6) begin miscompares++; $display("FAIL rr_keys0: got %h expected 6", bus.lock_keys); end
    vectors++;
    bus.lock_unlock = 1'b1;
    tick();
    bus.lock_unlock = 1'b0;
    repeat (8) tick();
    tick();
    if (bus.grant !== 2'b00) begin miscompares++; $display("FAIL rr_idle: got %b expected 00", bus.grant); end
    vectors++;
    tick();
    if (bus.grant !== 2'b10) begin miscompares++; $display("FAIL rr_second: got %b expected 10", bus.grant); end
    vectors++;
    tick();
    if (bus.lock_keys !== 4'h9) begin miscompares++; $display("FAIL rr_keys1: got %h expected 9", bus.lock_keys); end
    vectors++;
    bus.keys1 = 4'hA;
    #1;
    if (bus.lock_keys !== 4'hA) begin miscompares++; $display("FAIL rr_keys1_follow: got %h expected a", bus.lock_keys); end
    vectors++;
    bus.lock_unlock = 1'b1;
    tick();
    bus.lock_unlock = 1'b0; bus.req = 2'b00;
    if (bus.lock_keys !== 4'h0) begin miscompares++; $display("FAIL rr_open_keys: got %h expected 0", bus.lock_keys); end
    vectors++;
    repeat (8) tick();
    tick();
    bus.keys0 = 4'h0; bus.keys1 = 4'h0;
    if (bus.fail_count !== 2'd0) begin miscompares++; $display("FAIL rr_fails: got %0d expected 0", bus.fail_count); end
    vectors++;
  endtask

  // Keypad 0 enters a key then walks away; ends in the RELEASE cycle.
  task automatic fail_session(input logic [1:0] exp_fail);
    bus.req = 2'b01; bus.keys0 = 4'h0;
    tick();
    tick();
    bus.keys0 = 4'h2;
    tick();
    bus.req = 2'b00; bus.keys0 = 4'h0;
    tick();
    if (bus.fail_count !== exp_fail || bus.grant !== 2'b00) begin
      miscompares++; $display("FAIL fail_session: got fail=%0d grant=%b expected %0d/00", bus.fail_count, bus.grant, exp_fail);
    end
    vectors++;
  endtask

  task automatic test_lockout();
    int n;
    bit granted;
    fail_session(2'd1);
    tick();
    fail_session(2'd2);
    tick();
    fail_session(2'd3);
    if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL lo_early: got %b expected 0", bus.locked_out); end
    vectors++;
    bus.req = 2'b01;
    tick();
    n = 0;
    granted = 1'b0;
    while (bus.locked_out === 1'b1 && n < 200) begin
      if (bus.grant !== 2'b00) granted = 1'b1;
      n++;
      tick();
    end
    bus.req = 2'b00;
    if (n != 100) begin miscompares++; $display("FAIL lo_length: got %0d cycles expected 100", n); end
    vectors++;
    if (granted) begin miscompares++; $display("FAIL lo_grant: got grant during lockout expected none"); end
    vectors++;
    if (bus.fail_count !== 2'd0 || bus.grant !== 2'b00) begin
      miscompares++; $display("FAIL lo_exit: got fail=%0d grant=%b expected 0/00", bus.fail_count, bus.grant);
    end
    vectors++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus.req = 2'b01; bus.keys0 = 4'h0; bus.lock_progress = 4'h0;
    tick();
    tick();
    n = 0;
    while (bus.grant === 2'b01 && n < 200) begin
      if (n == 10) bus.lock_progress = 4'h1;
      n++;
      tick();
    end
    if (n != 75) begin miscompares++; $display("FAIL to_length: got %0d active cycles expected 75", n); end
    vectors++;
    if (bus.fail_count !== 2'd1 || bus.lock_rst !== 1'b1) begin
      miscompares++; $display("FAIL to_fail: got fail=%0d lock_rst=%b expected 1/1", bus.fail_count, bus.lock_rst);
    end
    vectors++;
    bus.req = 2'b00; bus.lock_progress = 4'h0;
    tick();
  endtask

  task automatic test_unlock_drop();
    bus.req = 2'b01; bus.keys0 = 4'h0;
    tick();
    tick();
    bus.keys0 = 4'h7;
    tick();
    bus.lock_unlock = 1'b1; bus.req = 2'b00;
    tick();
    bus.lock_unlock = 1'b0; bus.keys0 = 4'h0;
    if (bus.unlocked !== 1'b1 || bus.grant !== 2'b01) begin
      miscompares++; $display("FAIL ud_open: got unlocked=%b grant=%b expected 1/01", bus.unlocked, bus.grant);
    end
    vectors++;
    if (bus.fail_count !== 2'd0) begin miscompares++; $display("FAIL ud_fails: got %0d expected 0", bus.fail_count); end
    vectors++;
    count_open("ud");
    tick();
  endtask

  task automatic test_reset_mid();
    fail_session(2'd1);
    tick();
    fail_session(2'd2);
    tick();
    bus.req = 2'b01; bus.keys0 = 4'h0;
    tick();
    tick();
    if (bus.fail_count !== 2'd2 || bus.grant !== 2'b01) begin
      miscompares++; $display("FAIL rm_before: got fail=%0d grant=%b expected 2/01", bus.fail_count, bus.grant);
    end
    vectors++;
    reset = 1'b0;
    tick();
    if (bus.grant !== 2'b00 || bus.fail_count !== 2'd0 || bus.lock_rst !== 1'b1 || bus.lock_keys !== 4'h0) begin
      miscompares++; $display("FAIL rm_reset: got grant=%b fail=%0d lock_rst=%b keys=%h expected 00/0/1/0",
                              bus.grant, bus.fail_count, bus.lock_rst, bus.lock_keys);
    end
    vectors++;
    reset = 1'b1; bus.req = 2'b00;
    tick();
    if (bus.lock_rst !== 1'b0 || bus.grant !== 2'b00) begin
      miscompares++; $display("FAIL rm_idle: got lock_rst=%b grant=%b expected 0/00", bus.lock_rst, bus.grant);
    end
    vectors++;
    bus.req = 2'b11;
    tick();
    if (bus.grant !== 2'b01) begin miscompares++; $display("FAIL rm_pointer: got %b expected 01", bus.grant); end
    vectors++;
    bus.req = 2'b00;
    tick();
    tick();
    tick();
    if (bus.fail_count !== 2'd0 || bus.grant !== 2'b00) begin
      miscompares++; $display("FAIL rm_end: got fail=%0d grant=%b expected 0/00", bus.fail_count, bus.grant);
    end
    vectors++;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.req = 2'b00;
    bus.keys0 = 4'h0;
    bus.keys1 = 4'h0;
    bus.lock_unlock = 1'b0;
    bus.lock_progress = 4'h0;
    test_reset();
    test_open();
    test_round_robin();
    test_lockout();
    test_timeout();
    test_unlock_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 expected completion");
    $fatal(1);
  end

endmodule
